mem_fill_arbiter: RTL and testbench

Shared-memory controller between the I-cache and D-cache fill paths. It takes block-fill requests from both caches, grants the single pipelined memory to one requester at a time, issues the eight 16-bit word reads of the 16-byte block, and steers the returning beats back to the owner as data-array and tag-array write strobes. It sits between the two cache fill paths and the memory module, and its per-requester grant also serves as a pipeline stall source.

---
 rtl/mem_fill_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_fill_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// Arbitrates block fills from the I-cache and D-cache onto one pipelined memory.
// Issues eight word reads per block and steers the in-order beats back to the owner.
module mem_fill_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ic_req,
    input  logic [15:0] ic_addr,
    input  logic        dc_req,
    input  logic [15:0] dc_addr,
    input  logic        mem_data_valid,
    output logic        mem_enable,
    output logic [15:0] mem_address,
    output logic        ic_grant,
    output logic        dc_grant,
    output logic        ic_wr_data,
    output logic        dc_wr_data,
    output logic [2:0]  wr_word,
    output logic        ic_wr_tag,
    output logic        ic_done,
    output logic        dc_wr_tag,
    output logic        dc_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Requester encoding shared by owner and last_served.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_served_q, last_served_d;
    logic [2:0]  issue_cnt_q, issue_cnt_d;
    logic [2:0]  rcv_cnt_q, rcv_cnt_d;
    logic [11:0] blk_q, blk_d;

    logic beat;
    logic last_beat;
    logic pick_d;

    // Only the block-aligned part of a miss address selects the fill.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ic_addr[3:0], dc_addr[3:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            owner_q       <= OWN_I;
            last_served_q <= OWN_I;
            issue_cnt_q   <= 3'd0;
            rcv_cnt_q     <= 3'd0;
            blk_q         <= 12'd0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
            issue_cnt_q   <= issue_cnt_d;
            rcv_cnt_q     <= rcv_cnt_d;
            blk_q         <= blk_d;
        end
    end

    assign beat      = (state_q != S_IDLE) && mem_data_valid;
    assign last_beat = beat && (rcv_cnt_q == 3'd7);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        issue_cnt_d   = issue_cnt_q;
        rcv_cnt_d     = rcv_cnt_q;
        blk_d         = blk_q;
        pick_d        = OWN_I;

        case (state_q)
            S_IDLE: begin
                if (ic_req || dc_req) begin
                    // On a tie the requester not served last wins.
                    pick_d      = dc_req && (!ic_req || (last_served_q == OWN_I));
                    owner_d     = pick_d;
                    blk_d       = (pick_d == OWN_D) ? dc_addr[15:4] : ic_addr[15:4];
                    issue_cnt_d = 3'd0;
                    rcv_cnt_d   = 3'd0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue_cnt_d = issue_cnt_q + 3'd1;
                if (issue_cnt_q == 3'd7) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (beat) begin
            rcv_cnt_d = rcv_cnt_q + 3'd1;
        end
        // The final beat overrides the ISSUE->DRAIN step when it lands with word 7.
        if (last_beat) begin
            last_served_d = owner_q;
            state_d       = S_IDLE;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign mem_enable  = (state_q == S_ISSUE);
    assign mem_address = (state_q == S_ISSUE) ? {blk_q, issue_cnt_q, 1'b0} : 16'd0;
    assign ic_grant    = busy && (owner_q == OWN_I);
    assign dc_grant    = busy && (owner_q == OWN_D);
    assign wr_word     = rcv_cnt_q;
    assign ic_wr_data  = beat && (owner_q == OWN_I);
    assign dc_wr_data  = beat && (owner_q == OWN_D);
    assign ic_wr_tag   = last_beat && (owner_q == OWN_I);
    assign ic_done     = last_beat && (owner_q == OWN_I);
    assign dc_wr_tag   = last_beat && (owner_q == OWN_D);
    assign dc_done     = last_beat && (owner_q == OWN_D);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a fixed-latency pipelined memory model.
// Cycle n is the interval after rising edge n; outputs are sampled mid-cycle.
module tb_mem_fill_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ic_req;
    logic [15:0] ic_addr;
    logic        dc_req;
    logic [15:0] dc_addr;
    logic        mem_data_valid;
    logic        mem_enable;
    logic [15:0] mem_address;
    logic        ic_grant;
    logic        dc_grant;
    logic        ic_wr_data;
    logic        dc_wr_data;
    logic [2:0]  wr_word;
    logic        ic_wr_tag;
    logic        ic_done;
    logic        dc_wr_tag;
    logic        dc_done;
    logic        busy;

    int   n_cmp;
    int   n_err;
    int   lat;
    logic spur;
    logic pipe [8];

    mem_fill_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .dc_req         (dc_req),
        .dc_addr        (dc_addr),
        .mem_data_valid (mem_data_valid),
        .mem_enable     (mem_enable),
        .mem_address    (mem_address),
        .ic_grant       (ic_grant),
        .dc_grant       (dc_grant),
        .ic_wr_data     (ic_wr_data),
        .dc_wr_data     (dc_wr_data),
        .wr_word        (wr_word),
        .ic_wr_tag      (ic_wr_tag),
        .ic_done        (ic_done),
        .dc_wr_tag      (dc_wr_tag),
        .dc_done        (dc_done),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 8; i++) pipe[i] = 1'b0;
    endtask

    // Advance one cycle; memory returns each enable exactly lat cycles later.
    task automatic step();
        @(posedge clk);
        #1;
        mem_data_valid = pipe[lat-1] | spur;
        spur = 1'b0;
        for (int i = 7; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = mem_enable;
        #1;
    endtask

    task automatic check_quiet(input string tag, input bit with_addr);
        check_val({tag, " ic_grant"}, ic_grant, 0);
        check_val({tag, " dc_grant"}, dc_grant, 0);
        check_val({tag, " mem_enable"}, mem_enable, 0);
        check_val({tag, " ic_wr_data"}, ic_wr_data, 0);
        check_val({tag, " dc_wr_data"}, dc_wr_data, 0);
        check_val({tag, " strobes"}, {ic_wr_tag, ic_done, dc_wr_tag, dc_done}, 0);
        check_val({tag, " busy"}, busy, 0);
        if (with_addr) begin
            check_val({tag, " mem_address"}, mem_address, 0);
            check_val({tag, " wr_word"}, wr_word, 0);
        end
    endtask

    // Caller has set the winning req in cycle 0 (state IDLE). Checks cycles 1..9+lat.
    task automatic run_fill(input bit is_d, input logic [15:0] base, input int drop_at, input int other_at);
        int    nc;
        logic  eg, emem, ebeat, edone;
        string t;
        nc = 9 + lat;
        for (int c = 1; c <= nc; c++) begin
            step();
            eg    = (c <= 8 + lat);
            emem  = (c <= 8);
            ebeat = (c >= 1 + lat) && (c <= 8 + lat);
            edone = (c == 8 + lat);
            t = $sformatf("%s@%0h c%0d", is_d ? "D" : "I", base, c);
            check_val({t, " own_grant"}, is_d ? dc_grant : ic_grant, eg);
            check_val({t, " oth_grant"}, is_d ? ic_grant : dc_grant, 0);
            check_val({t, " busy"}, busy, eg);
            check_val({t, " mem_enable"}, mem_enable, emem);
            if (emem) check_val({t, " mem_address"}, mem_address, base + 16'(2 * (c - 1)));
            check_val({t, " own_wr_data"}, is_d ? dc_wr_data : ic_wr_data, ebeat);
            check_val({t, " oth_wr_data"}, is_d ? ic_wr_data : dc_wr_data, 0);
            if (ebeat) check_val({t, " wr_word"}, wr_word, 32'(c - 1 - lat));
            check_val({t, " own_tag"}, is_d ? dc_wr_tag : ic_wr_tag, edone);
            check_val({t, " own_done"}, is_d ? dc_done : ic_done, edone);
            check_val({t, " oth_tag_done"}, is_d ? {ic_wr_tag, ic_done} : {dc_wr_tag, dc_done}, 0);
            if (edone) $display("fill %s blk %0h done in cycle %0d (L=%0d)", is_d ? "D" : "I", base, c, lat);
            // Latched block address must survive the requester changing its address.
            if (c == 2) begin
                if (is_d) dc_addr = ~base;
                else      ic_addr = ~base;
            end
            if (c == drop_at) begin
                if (is_d) dc_req = 1'b0;
                else      ic_req = 1'b0;
            end
            if (c == other_at) begin
                if (is_d) ic_req = 1'b1;
                else      dc_req = 1'b1;
            end
            if (edone) begin
                if (is_d) dc_req = 1'b0;
                else      ic_req = 1'b0;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        lat = 4;
        spur = 1'b0;
        clear_pipe();
        rst_n = 1'b0;
        ic_req = 1'b0;
        dc_req = 1'b0;
        ic_addr = 16'h0;
        dc_addr = 16'h0;
        mem_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset", 1'b1);
        rst_n = 1'b1;
        step();
        check_quiet("after_reset", 1'b1);

        // Simultaneous requests after reset: D first, then I, then D again on a tie.
        dc_addr = 16'hA000;
        ic_addr = 16'h4000;
        dc_req = 1'b1;
        ic_req = 1'b1;
        run_fill(1'b1, 16'hA000, -1, -1);
        ic_addr = 16'h4000;
        run_fill(1'b0, 16'h4000, -1, -1);
        dc_addr = 16'hB120;
        ic_addr = 16'h7770;
        dc_req = 1'b1;
        ic_req = 1'b1;
        run_fill(1'b1, 16'hB120, -1, -1);
        ic_addr = 16'h7770;
        run_fill(1'b0, 16'h7770, -1, -1);

        // Single I-miss at a non-aligned address.
        step();
        ic_addr = 16'h1236;
        ic_req = 1'b1;
        run_fill(1'b0, 16'h1230, -1, -1);

        // Contention: D requests in cycle 3 of an I fill and is granted in cycle 14.
        ic_addr = 16'h2220;
        dc_addr = 16'hC340;
        ic_req = 1'b1;
        run_fill(1'b0, 16'h2220, -1, 3);
        dc_addr = 16'hC340;
        run_fill(1'b1, 16'hC340, -1, -1);

        // Spurious beat in IDLE, then a fill whose req drops in cycle 2.
        spur = 1'b1;
        step();
        check_quiet("spurious", 1'b0);
        ic_addr = 16'h3450;
        ic_req = 1'b1;
        run_fill(1'b0, 16'h3450, 2, -1);

        // Reset mid-fill in cycle 6, then a fresh D fill.
        ic_addr = 16'h6660;
        ic_req = 1'b1;
        for (int c = 1; c <= 6; c++) step();
        check_val("pre_reset ic_grant", ic_grant, 1);
        rst_n = 1'b0;
        mem_data_valid = 1'b0;
        clear_pipe();
        ic_req = 1'b0;
        #1;
        check_quiet("mid_reset", 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dc_addr = 16'h5550;
        dc_req = 1'b1;
        run_fill(1'b1, 16'h5550, -1, -1);

        // Latency sweep: L=1, done in cycle 9.
        lat = 1;
        clear_pipe();
        ic_addr = 16'h1236;
        ic_req = 1'b1;
        run_fill(1'b0, 16'h1230, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
